// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one open-drain I2C pad set among N_MASTERS engines.
// Optional SCL-low stall timeout is compiled in with `define I2C_ARB_TIMEOUT_EN.
module i2c_bus_arbiter #(
   parameter int N_MASTERS       = 2,
   parameter int BUS_FREE_CYCLES = 8,
   parameter int TIMEOUT_CYCLES  = 65535
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_MASTERS-1:0] req,
   output logic [N_MASTERS-1:0] gnt,
   input  logic [N_MASTERS-1:0] m_scl_o,
   input  logic [N_MASTERS-1:0] m_scl_t,
   input  logic [N_MASTERS-1:0] m_sda_o,
   input  logic [N_MASTERS-1:0] m_sda_t,
   input  logic                 scl_i,
   input  logic                 sda_i,
   output logic                 scl_o,
   output logic                 scl_t,
   output logic                 sda_o,
   output logic                 sda_t,
   output logic                 bus_busy,
   output logic                 timeout
);

   localparam int PW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
   localparam int FW = $clog2(BUS_FREE_CYCLES + 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT_FREE, S_GRANT, S_RELEASE} state_t;

   state_t                state_reg;
   logic [1:0]            scl_sync_reg;
   logic [1:0]            sda_sync_reg;
   logic                  scl_d_reg;
   logic                  sda_d_reg;
   logic                  bus_busy_reg;
   logic [FW-1:0]         free_cnt_reg;
   logic [PW-1:0]         rr_ptr_reg;
   logic [N_MASTERS-1:0]  gnt_reg;

   logic                  scl_s;
   logic                  sda_s;
   logic                  start_det;
   logic                  stop_det;
   logic                  bus_quiet;
   logic                  gnt_held;
   logic [N_MASTERS-1:0]  req_eff;
   logic [PW-1:0]         pick_idx;
   logic [N_MASTERS-1:0]  pick_onehot;
   logic                  no_gnt;

   assign scl_s     = scl_sync_reg[1];
   assign sda_s     = sda_sync_reg[1];
   assign start_det = scl_s & scl_d_reg & sda_d_reg & ~sda_s;
   assign stop_det  = scl_s & scl_d_reg & ~sda_d_reg & sda_s;
   assign bus_quiet = scl_s & sda_s;
   assign gnt_held  = |(gnt_reg & req);

`ifdef I2C_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0]         to_cnt_reg;
   logic [N_MASTERS-1:0]  blocked_reg;
   logic                  timeout_reg;

   // A master that timed out stays masked until it withdraws its request.
   assign req_eff = req & ~blocked_reg;
   assign timeout = timeout_reg;
`else
   assign req_eff = req;
   assign timeout = 1'b0;
`endif

   // First requester strictly after the RR pointer, wrapping around.
   always_comb begin
      int idx;
      pick_idx    = '0;
      pick_onehot = '0;
      idx         = 0;
      for (int i = N_MASTERS; i >= 1; i--) begin
         idx = (int'(rr_ptr_reg) + i) % N_MASTERS;
         if (req_eff[idx]) begin
            pick_idx         = PW'(idx);
            pick_onehot      = '0;
            pick_onehot[idx] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= S_IDLE;
         scl_sync_reg <= 2'b11;
         sda_sync_reg <= 2'b11;
         scl_d_reg    <= 1'b1;
         sda_d_reg    <= 1'b1;
         bus_busy_reg <= 1'b0;
         free_cnt_reg <= '0;
         rr_ptr_reg   <= PW'(N_MASTERS - 1);
         gnt_reg      <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
         to_cnt_reg   <= '0;
         blocked_reg  <= '0;
         timeout_reg  <= 1'b0;
`endif
      end else begin
         scl_sync_reg <= {scl_sync_reg[0], scl_i};
         sda_sync_reg <= {sda_sync_reg[0], sda_i};
         scl_d_reg    <= scl_s;
         sda_d_reg    <= sda_s;
         if (stop_det)
            bus_busy_reg <= 1'b0;
         else if (start_det)
            bus_busy_reg <= 1'b1;
`ifdef I2C_ARB_TIMEOUT_EN
         timeout_reg <= 1'b0;
         blocked_reg <= blocked_reg & req;
`endif
         case (state_reg)
            S_IDLE: begin
               free_cnt_reg <= '0;
               if (|req_eff)
                  state_reg <= S_WAIT_FREE;
            end
            S_WAIT_FREE: begin
               if (!(|req_eff)) begin
                  free_cnt_reg <= '0;
                  state_reg    <= S_IDLE;
               end else if (free_cnt_reg == FW'(BUS_FREE_CYCLES)) begin
                  free_cnt_reg <= '0;
                  gnt_reg      <= pick_onehot;
                  rr_ptr_reg   <= pick_idx;
                  state_reg    <= S_GRANT;
               end else if (bus_quiet && !bus_busy_reg) begin
                  free_cnt_reg <= free_cnt_reg + 1'b1;
               end else begin
                  free_cnt_reg <= '0;
               end
            end
            S_GRANT: begin
               if (!gnt_held) begin
                  gnt_reg   <= '0;
                  state_reg <= S_RELEASE;
`ifdef I2C_ARB_TIMEOUT_EN
                  to_cnt_reg <= '0;
               end else if (!scl_s) begin
                  if (to_cnt_reg == TW'(TIMEOUT_CYCLES - 1)) begin
                     to_cnt_reg  <= '0;
                     gnt_reg     <= '0;
                     timeout_reg <= 1'b1;
                     blocked_reg <= (blocked_reg & req) | gnt_reg;
                     state_reg   <= S_RELEASE;
                  end else begin
                     to_cnt_reg <= to_cnt_reg + 1'b1;
                  end
               end else begin
                  to_cnt_reg <= '0;
`endif
               end
            end
            S_RELEASE: begin
               // A master that quit mid-transaction leaves bus_busy set; recover after a quiet interval.
               if (!bus_busy_reg) begin
                  free_cnt_reg <= '0;
                  state_reg    <= S_IDLE;
               end else if (free_cnt_reg == FW'(BUS_FREE_CYCLES)) begin
                  free_cnt_reg <= '0;
                  bus_busy_reg <= 1'b0;
                  state_reg    <= S_IDLE;
               end else if (bus_quiet) begin
                  free_cnt_reg <= free_cnt_reg + 1'b1;
               end else begin
                  free_cnt_reg <= '0;
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   assign gnt      = gnt_reg;
   assign bus_busy = bus_busy_reg;
   assign no_gnt   = ~|gnt_reg;
   assign scl_o    = no_gnt | |(gnt_reg & m_scl_o);
   assign scl_t    = no_gnt | |(gnt_reg & m_scl_t);
   assign sda_o    = no_gnt | |(gnt_reg & m_sda_o);
   assign sda_t    = no_gnt | |(gnt_reg & m_sda_t);

endmodule

// File: doc/i2c_bus_arbiter.md
Name: i2c_bus_arbiter

Overview:
- Shares one open-drain I2C pad set (scl/sda, split _i/_o/_t tristate form) among N_MASTERS internal master engines.
- Tracks bus state from pad inputs: START/STOP detection, plus a bus-free interval before any grant.
- Grants round-robin, one transaction per grant, and muxes the granted master's scl/sda drive onto the pad.
- Sits between the master engines and the top-level IOBUF tristate pins.

Parameters:
N_MASTERS, 2, number of requesting master engines (2..8)
BUS_FREE_CYCLES, 8, consecutive clk cycles with synced SCL=1, SDA=1 and no bus activity required before a grant
TIMEOUT_CYCLES, 65535, SCL-low stall limit while granted (optional feature only)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
req  input  N_MASTERS  per-master request; held high for the whole transaction
gnt  output  N_MASTERS  one-hot grant, registered
m_scl_o  input  N_MASTERS  per-master SCL output value
m_scl_t  input  N_MASTERS  per-master SCL tristate (1 = released)
m_sda_o  input  N_MASTERS  per-master SDA output value
m_sda_t  input  N_MASTERS  per-master SDA tristate (1 = released)
scl_i  input  1  pad SCL input
sda_i  input  1  pad SDA input
scl_o  output  1  pad SCL output value
scl_t  output  1  pad SCL tristate
sda_o  output  1  pad SDA output value
sda_t  output  1  pad SDA tristate
bus_busy  output  1  START seen and no STOP yet (any master, internal or external)
timeout  output  1  one-cycle pulse on forced release (optional feature only)

Behaviour:
- Pad inputs pass through a 2-FF synchronizer, then a 1-cycle history register. All detection uses synced values.
- START = synced SDA 1->0 while SCL=1; STOP = synced SDA 0->1 while SCL=1.
- bus_busy: set the cycle after START, cleared the cycle after STOP. If both are flagged in one cycle, STOP wins.
- Pad mux: combinational from registered gnt.
  - No grant: scl_o=1, scl_t=1, sda_o=1, sda_t=1.
  - Granted master k: pad = m_*[k].
- Reset: state=IDLE, gnt=0, bus_busy=0, free counter=0, RR pointer=N_MASTERS-1 (so master 0 wins first), timeout=0; pad released.
- FSM:
  - IDLE: any req -> WAIT_FREE; free counter cleared.
  - WAIT_FREE: counter increments while !bus_busy and SCL=1 and SDA=1, and clears to 0 otherwise.
    - Counter reaches BUS_FREE_CYCLES: if any req is still high, pick the first req after the RR pointer (wrapping), set gnt, update pointer, -> GRANT.
    - Otherwise -> IDLE.
    - All req dropping before the count completes -> IDLE, no grant.
  - GRANT: gnt held stable. Requests from other masters are ignored.
    - Granted req falls -> RELEASE; gnt cleared on the same edge.
  - RELEASE: pad released.
    - !bus_busy -> IDLE.
    - If bus_busy stays high (master dropped req without STOP), wait until SCL=1 and SDA=1 have held for BUS_FREE_CYCLES, then clear bus_busy and -> IDLE.
- Latency: req to gnt = 1 (IDLE->WAIT_FREE) + BUS_FREE_CYCLES + 1 cycles minimum on a quiet bus.
- Back-to-back: after release, a pending req from another master re-enters WAIT_FREE, so the bus-free interval always separates grants.
- External master traffic (START from a master not in this block) only affects bus_busy. It delays grants but never revokes one.
- Reset mid-GRANT: gnt drops the next edge and the pad releases. Any partial transaction is abandoned.

Optional Feature:
- Macro: I2C_ARB_TIMEOUT_EN.
- Defined:
  - In GRANT, a counter increments each cycle synced SCL=0 and clears when SCL=1.
  - At TIMEOUT_CYCLES: gnt cleared, pad released, timeout pulses 1 cycle, -> RELEASE.
  - The RR pointer still advances past the offender.
  - The offending master must drop req and re-request before it can be granted again.
- Undefined: no counter, timeout tied 0, GRANT exits only on req fall.

Test Plan:
1. Reset, idle bus, req=2'b01 at cycle 0 -> gnt=2'b01 at cycle 1+8+1=10; pad equals m_*[0] from that cycle; pad fully released before it.
2. req=2'b11 simultaneously -> master 0 granted. Drop req[0] with a STOP on the pad -> RELEASE -> IDLE; master 1 granted 8 free cycles later. Repeat: master 0 wins the next round.
3. External START (SDA 1->0 with SCL=1) while req[1]=1 in WAIT_FREE -> bus_busy=1 3 cycles later, counter held at 0, no grant until STOP plus 8 quiet cycles.
4. req[0] dropped at free count 5 -> back to IDLE, gnt stays 0, pad stays released.
5. rst asserted mid-GRANT with master 0 driving sda_t=0 -> next edge: gnt=0, sda_t=1, scl_t=1, bus_busy=0.
6. (I2C_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=100) granted master holds m_scl_t=0, m_scl_o=0 -> timeout pulse at 100 SCL-low cycles, gnt=0, pad released; without the macro gnt stays held.
